// File: rtl/sync_midpoint_predictor.sv
// sync_midpoint_predictor: predicts the midpoint of the next opposite-side SYNC pulse
// from wrap-safe rise/fall midpoints and an averaged history of half-periods.
module sync_midpoint_predictor #(
  parameter int             TW        = 32,
  parameter int             LOG2_HIST = 2,
  parameter logic [TW-1:0]  MAX_PULSE = TW'('hFFFF)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [TW-1:0] i_lsync_rise_time,
  input  logic [TW-1:0] i_lsync_fall_time,
  input  logic [TW-1:0] i_rsync_rise_time,
  input  logic [TW-1:0] i_rsync_fall_time,
  input  logic          i_scan_dir,
  input  logic          i_sync_pulse,
  input  logic          i_clear,
  output logic [TW-1:0] o_pred_time,
  output logic          o_pred_valid,
  output logic          o_pred_dir,
  output logic          o_hist_full,
  output logic          o_err_width,
  output logic          o_err_dir
);
  localparam int DEPTH = 1 << LOG2_HIST;
  localparam int SW    = TW + LOG2_HIST;
  localparam int CW    = LOG2_HIST + 1;
  localparam int PW    = (LOG2_HIST > 0) ? LOG2_HIST : 1;

  logic [TW-1:0] w_rise, w_fall, w_d, w_mid;
  logic          w_werr;
  logic          r_s1_v, r_s1_dir, r_s1_werr;
  logic [TW-1:0] r_s1_mid;

  always_comb begin
    w_rise = i_scan_dir ? i_rsync_rise_time : i_lsync_rise_time;
    w_fall = i_scan_dir ? i_rsync_fall_time : i_lsync_fall_time;
    w_d    = w_fall - w_rise;
    w_mid  = w_rise + (w_d >> 1);
    w_werr = w_d > MAX_PULSE;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1_v    <= 1'b0;
      r_s1_dir  <= 1'b0;
      r_s1_werr <= 1'b0;
      r_s1_mid  <= '0;
    end else begin
      r_s1_v    <= i_sync_pulse & ~i_clear;
      r_s1_dir  <= i_scan_dir;
      r_s1_werr <= w_werr;
      r_s1_mid  <= w_mid;
    end
  end

  logic [TW-1:0] r_last_l, r_last_r;
  logic          r_lv, r_rv, r_have_dir, r_last_dir;
  logic [TW-1:0] r_hist [DEPTH];
  logic [PW-1:0] r_wp;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_sum;

  logic          w_tok, w_derr, w_opp_v, w_push, w_full, w_full_n;
  logic [TW-1:0] w_opp, w_h, w_evict, w_avg;
  logic [SW-1:0] w_sum_n;
  logic [CW-1:0] w_count_n;
  logic [PW-1:0] w_wp_n;

  // Every piece of shared state is read and written only here, so back-to-back tokens need no forwarding.
  always_comb begin
    w_tok     = r_s1_v & ~r_s1_werr & ~i_clear;
    w_derr    = r_have_dir & (r_s1_dir == r_last_dir);
    w_opp_v   = r_s1_dir ? r_lv : r_rv;
    w_opp     = r_s1_dir ? r_last_l : r_last_r;
    w_push    = w_tok & ~w_derr & w_opp_v;
    w_h       = r_s1_mid - w_opp;
    w_full    = r_count == CW'(DEPTH);
    w_evict   = w_full ? r_hist[r_wp] : '0;
    w_sum_n   = r_sum + SW'(w_h) - SW'(w_evict);
    w_count_n = w_full ? r_count : r_count + 1'b1;
    w_full_n  = w_count_n == CW'(DEPTH);
    w_avg     = w_full_n ? TW'(w_sum_n >> LOG2_HIST) : w_h;
    w_wp_n    = (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_last_l   <= '0;
      r_last_r   <= '0;
      r_lv       <= 1'b0;
      r_rv       <= 1'b0;
      r_have_dir <= 1'b0;
      r_last_dir <= 1'b0;
      r_wp       <= '0;
      r_count    <= '0;
      r_sum      <= '0;
      for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
    end else if (i_clear) begin
      r_lv       <= 1'b0;
      r_rv       <= 1'b0;
      r_have_dir <= 1'b0;
      r_wp       <= '0;
      r_count    <= '0;
      r_sum      <= '0;
    end else if (w_tok) begin
      if (r_s1_dir) begin
        r_last_r <= r_s1_mid;
        r_rv     <= 1'b1;
      end else begin
        r_last_l <= r_s1_mid;
        r_lv     <= 1'b1;
      end
      r_have_dir <= 1'b1;
      r_last_dir <= r_s1_dir;
      if (w_push) begin
        r_hist[r_wp] <= w_h;
        r_wp         <= w_wp_n;
        r_sum        <= w_sum_n;
        r_count      <= w_count_n;
      end
    end
  end

  logic          r_s2_pred, r_s2_derr, r_s2_werr, r_s2_dir;
  logic [TW-1:0] r_s2_mid, r_s2_avg;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s2_pred <= 1'b0;
      r_s2_derr <= 1'b0;
      r_s2_werr <= 1'b0;
      r_s2_dir  <= 1'b0;
      r_s2_mid  <= '0;
      r_s2_avg  <= '0;
    end else begin
      r_s2_pred <= w_push;
      r_s2_derr <= w_tok & w_derr;
      r_s2_werr <= r_s1_v & r_s1_werr & ~i_clear;
      r_s2_dir  <= r_s1_dir;
      r_s2_mid  <= r_s1_mid;
      r_s2_avg  <= w_avg;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pred_time  <= '0;
      o_pred_valid <= 1'b0;
      o_pred_dir   <= 1'b0;
      o_err_width  <= 1'b0;
      o_err_dir    <= 1'b0;
    end else begin
      o_pred_valid <= r_s2_pred & ~i_clear;
      o_err_width  <= r_s2_werr & ~i_clear;
      o_err_dir    <= r_s2_derr & ~i_clear;
      if (r_s2_pred & ~i_clear) begin
        o_pred_time <= r_s2_mid + r_s2_avg;
        o_pred_dir  <= ~r_s2_dir;
      end
    end
  end

  assign o_hist_full = w_full;
endmodule
